muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer that owns the HI/LO register pair for the multicycle CPU.
//  The main FSM issues mult/multu/div/divu via start and stalls on busy before mfhi/mflo.
//  It also services mthi/mtlo writes.
//  One result bit is produced per clock (shift-add multiply, restoring divide), then a sign fix-up.

---
 rtl/muldiv_seq.sv | 101 ++++++++++
 tb/tb_muldiv_seq.sv | 116 +++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer owning the HI/LO register pair
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_div, r_sa, r_sb, r_dz;
  logic [WIDTH-1:0] r_opd, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic w_sa, w_sb, w_take, w_borrow, w_neg;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_acc_hi, w_acc_lo, w_diff, w_quo, w_rem;
  logic [WIDTH:0] w_sum, w_shift;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
  assign w_take = (r_state == IDLE) && start;
  assign w_sa = ~op[0] & a[WIDTH-1];
  assign w_sb = ~op[0] & b[WIDTH-1];
  assign w_abs_a = w_sa ? -a : a;
  assign w_abs_b = w_sb ? -b : b;
  assign w_acc_hi = r_acc[2*WIDTH-1:WIDTH];
  assign w_acc_lo = r_acc[WIDTH-1:0];
  assign w_sum = {1'b0, w_acc_hi} + {1'b0, r_opd};
  assign w_mul_next = r_acc[0] ? {w_sum, w_acc_lo[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
  assign w_shift = {w_acc_hi, w_acc_lo[WIDTH-1]};
  assign w_borrow = w_shift < {1'b0, r_opd};
  // A successful trial always leaves a remainder below the divisor, so WIDTH bits suffice
  assign w_diff = w_shift[WIDTH-1:0] - r_opd;
  assign w_div_next = {w_borrow ? w_shift[WIDTH-1:0] : w_diff, w_acc_lo[WIDTH-2:0], ~w_borrow};
  assign w_neg = r_sa ^ r_sb;
  assign w_prod = w_neg ? -r_acc : r_acc;
  assign w_quo = r_dz ? '1 : (w_neg ? -w_acc_lo : w_acc_lo);
  // With a zero divisor the remainder is |a|, so restoring the sign of a yields a as issued
  assign w_rem = r_sa ? -w_acc_hi : w_acc_hi;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign hi = r_hi;
  assign lo = r_lo;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // Next-state logic: IDLE -> CALC (WIDTH cycles) -> FIXUP -> DONE -> IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? CALC : IDLE;
      CALC:    w_next = (r_cnt == '0) ? FIXUP : CALC;
      FIXUP:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // Operand latch on accept, then one shift-add or restoring-divide step per CALC cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_div <= 1'b0;
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      r_dz <= 1'b0;
      r_opd <= '0;
      r_acc <= '0;
    end else if (w_take) begin
      r_cnt <= CW'(WIDTH - 1);
      r_div <= op[1];
      r_sa <= w_sa;
      r_sb <= w_sb;
      r_dz <= op[1] && (b == '0);
      r_opd <= op[1] ? w_abs_b : w_abs_a;
      r_acc <= {{WIDTH{1'b0}}, op[1] ? w_abs_a : w_abs_b};
    end else if (r_state == CALC) begin
      r_acc <= r_div ? w_div_next : w_mul_next;
      r_cnt <= r_cnt - CW'(1);
    end
  // HI/LO: sign-corrected result at the end of FIXUP, mthi/mtlo only when idle and not starting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == FIXUP) begin
      r_hi <= r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
      r_lo <= r_div ? w_quo : w_prod[WIDTH-1:0];
    end else if (r_state == IDLE && !start) begin
      if (mthi) r_hi <= wdata;
      if (mtlo) r_lo <= wdata;
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table plus multi-cycle corner sequences for muldiv_seq
module tb_muldiv_seq;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, start = 0, mthi = 0, mtlo = 0;
  logic [1:0] op = '0;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [W-1:0] hi, lo, hi0, lo0;
  int total = 0, bad = 0;
  typedef struct {logic [1:0] op; logic [W-1:0] a, b, hi, lo;} vec_t;
  vec_t v[14];
  always #5 clk = ~clk;
  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  // Presents start for one cycle (cycle 0); returns 1 ns after the edge that begins cycle 1
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit with_mthi);
    @(negedge clk);
    hi0 = hi; lo0 = lo;
    start = 1; op = o; a = x; b = y;
    mthi = with_mthi; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 0; mthi = 0; op = ~o; a = ~x; b = ~y;
  endtask
  // Follows the op from cycle c0 until done, checking latency, busy, held HI/LO and the result
  task automatic finish_op(input string n, input int c0, input logic [W-1:0] eh, input logic [W-1:0] el);
    int lat = -1;
    bit held = 1, bsy = 1;
    for (int c = c0; c <= c0 + 60 && lat < 0; c++) begin
      if (c > c0) begin @(posedge clk); #1; end
      if (!busy) bsy = 0;
      if (done) lat = c;
      else if (hi !== hi0 || lo !== lo0) held = 0;
    end
    chk({n, " latency"}, 64'(lat), 64'd34);
    chk({n, " busy"}, 64'(bsy), 64'd1);
    chk({n, " hold"}, 64'(held), 64'd1);
    chk({n, " hi"}, 64'(hi), 64'(eh));
    chk({n, " lo"}, 64'(lo), 64'(el));
    @(posedge clk); #1;
    chk({n, " pulse"}, {62'd0, done, busy}, 64'd0);
  endtask
  initial begin
    bit nd;
    v[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    v[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[3]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    v[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[5]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    v[6]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    v[7]  = '{2'b00, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000000, 32'h00000010};
    v[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    v[9]  = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14};
    v[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    v[11] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    v[12] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
    v[13] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    #12;
    chk("reset state", {30'd0, busy, done, hi}, 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("after release", {62'd0, busy, done}, 64'd0);
    for (int i = 0; i < 14; i++) begin
      issue(v[i].op, v[i].a, v[i].b, 0);
      finish_op($sformatf("vec%0d", i), 1, v[i].hi, v[i].lo);
    end
    @(negedge clk); mtlo = 1; wdata = 32'h12345678;
    @(posedge clk); #1; mtlo = 0;
    chk("mtlo idle", 64'(lo), 64'h12345678);
    @(negedge clk); mthi = 1; mtlo = 1; wdata = 32'hCAFEF00D;
    @(posedge clk); #1; mthi = 0; mtlo = 0;
    chk("mthi+mtlo idle", {hi, lo}, 64'hCAFEF00D_CAFEF00D);
    issue(2'b01, 32'd6, 32'd7, 0);
    @(negedge clk); mtlo = 1; wdata = 32'h12345678;
    @(posedge clk); #1; mtlo = 0;
    chk("mtlo busy", 64'(lo), 64'hCAFEF00D);
    finish_op("mt_busy", 2, 32'd0, 32'd42);
    issue(2'b00, 32'd2, 32'hFFFFFFFF, 1);
    chk("start+mthi hi", 64'(hi), 64'd0);
    finish_op("start_mthi", 1, 32'hFFFFFFFF, 32'hFFFFFFFE);
    issue(2'b00, 32'd2, 32'd3, 0);
    repeat (9) @(posedge clk);
    #1;
    issue(2'b01, 32'd5, 32'd5, 0);
    finish_op("double_start", 11, 32'd0, 32'd6);
    issue(2'b10, 32'd100, 32'd7, 0);
    repeat (14) @(posedge clk);
    #1;
    @(negedge clk); rst_n = 0;
    #1;
    chk("mid reset", {30'd0, busy, done, hi}, 64'd0);
    chk("mid reset lo", 64'(lo), 64'd0);
    @(negedge clk); rst_n = 1;
    nd = 1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) nd = 0;
    end
    chk("no done after reset", 64'(nd), 64'd1);
    issue(2'b11, 32'd9, 32'd2, 0);
    finish_op("divu_after_reset", 1, 32'd1, 32'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
